// File: rtl/vram_addr_sequencer.sv
// Four-phase character-cycle sequencer for the VRAM address mux: drives select/enable,
// produces the video scan address and slots one CPU access per character cycle.
`timescale 1ns / 1ps
module vram_addr_sequencer #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned SCAN_START = 0,
    parameter int unsigned SCAN_LAST  = 2047
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              cpu_req,
    input  logic              cpu_rnw,
    input  logic              scan_restart,
    output logic              nSELA,
    output logic              nG,
    output logic [ADDR_W-1:0] scan_addr,
    output logic              vid_latch,
    output logic              nWE,
    output logic              cpu_ack,
    output logic              cpu_wait
);

    localparam logic [ADDR_W-1:0] L_START = ADDR_W'(SCAN_START);
    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(SCAN_LAST);

    typedef enum logic [1:0] {
        VID_SETUP  = 2'd0,
        VID_LATCH  = 2'd1,
        CPU_SETUP  = 2'd2,
        CPU_ACCESS = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_pend;
    logic              w_pend_next;
    logic              r_rnw;
    logic              w_rnw_next;
    logic              r_restart;
    logic              w_restart_next;
    logic [ADDR_W-1:0] r_scan;
    logic [ADDR_W-1:0] w_scan_next;
    logic              r_nsela;
    logic              r_ng;
    logic              r_vid_latch;
    logic              r_nwe;
    logic              r_ack;
    logic              w_update;
    logic              w_ack_next;

    always_comb begin
        w_state_next = r_state;
        if (ce) begin
            case (r_state)
                VID_SETUP:  w_state_next = VID_LATCH;
                VID_LATCH:  w_state_next = CPU_SETUP;
                CPU_SETUP:  w_state_next = CPU_ACCESS;
                CPU_ACCESS: w_state_next = VID_SETUP;
                default:    w_state_next = VID_SETUP;
            endcase
        end
    end

    // Scan address and CPU capture both happen as the mux leaves the video phase,
    // so the B inputs never change while they are selected.
    always_comb begin
        w_update       = ce && (r_state == VID_LATCH);
        w_ack_next     = ce && (r_state == CPU_ACCESS) && r_pend;
        w_pend_next    = r_pend;
        w_rnw_next     = r_rnw;
        w_restart_next = r_restart | scan_restart;
        w_scan_next    = r_scan;
        if (w_update) begin
            w_pend_next    = cpu_req;
            w_rnw_next     = cpu_rnw;
            w_restart_next = 1'b0;
            if (r_restart || scan_restart) begin
                w_scan_next = L_START;
            end else if (r_scan == L_LAST) begin
                w_scan_next = L_START;
            end else begin
                w_scan_next = r_scan + ADDR_W'(1);
            end
        end else if (ce && (r_state == CPU_ACCESS)) begin
            w_pend_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= VID_SETUP;
            r_pend      <= 1'b0;
            r_rnw       <= 1'b1;
            r_restart   <= 1'b0;
            r_scan      <= L_START;
            r_nsela     <= 1'b1;
            r_ng        <= 1'b1;
            r_vid_latch <= 1'b0;
            r_nwe       <= 1'b1;
            r_ack       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pend      <= w_pend_next;
            r_rnw       <= w_rnw_next;
            r_restart   <= w_restart_next;
            r_scan      <= w_scan_next;
            // Outputs are registered from the next state so they change glitch-free with it.
            r_nsela     <= (w_state_next == VID_SETUP) || (w_state_next == VID_LATCH);
            r_ng        <= 1'b0;
            r_vid_latch <= (w_state_next == VID_LATCH);
            r_nwe       <= ~((w_state_next == CPU_ACCESS) && w_pend_next && !w_rnw_next);
            r_ack       <= w_ack_next;
        end
    end

    assign nSELA     = r_nsela;
    assign nG        = r_ng;
    assign scan_addr = r_scan;
    assign vid_latch = r_vid_latch;
    assign nWE       = r_nwe;
    assign cpu_ack   = r_ack;
    assign cpu_wait  = cpu_req & ~r_ack;

endmodule

// File: tb/tb_vram_addr_sequencer.sv
// Self-checking bench for vram_addr_sequencer: directed scenarios plus a randomized run
// against a phase-counting reference model.
`timescale 1ns / 1ps
module tb_vram_addr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b0;
    logic        cpu_req = 1'b0;
    logic        cpu_rnw = 1'b1;
    logic        scan_restart = 1'b0;
    logic        nSELA;
    logic        nG;
    logic [11:0] scan_addr;
    logic        vid_latch;
    logic        nWE;
    logic        cpu_ack;
    logic        cpu_wait;

    int tests = 0;
    int failed = 0;

    // Reference model: character-cycle phase as a counter of ce edges modulo 4.
    int m_phase = 0;
    int m_scan = 0;
    bit m_ng = 1'b1;
    bit m_pend = 1'b0;
    bit m_rnw = 1'b1;
    bit m_restart = 1'b0;
    bit m_ack = 1'b0;

    vram_addr_sequencer #(
        .ADDR_W     (12),
        .SCAN_START (0),
        .SCAN_LAST  (2047)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ce           (ce),
        .cpu_req      (cpu_req),
        .cpu_rnw      (cpu_rnw),
        .scan_restart (scan_restart),
        .nSELA        (nSELA),
        .nG           (nG),
        .scan_addr    (scan_addr),
        .vid_latch    (vid_latch),
        .nWE          (nWE),
        .cpu_ack      (cpu_ack),
        .cpu_wait     (cpu_wait)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit upd;
        if (rst) begin
            m_ng = 1'b1; m_phase = 0; m_scan = 0; m_pend = 1'b0; m_restart = 1'b0; m_ack = 1'b0;
        end else begin
            m_ng = 1'b0;
            m_ack = ce && (m_phase == 3) && m_pend;
            upd = ce && (m_phase == 1);
            if (upd) begin
                if (m_restart || scan_restart || m_scan == 2047) m_scan = 0;
                else m_scan = m_scan + 1;
                m_restart = 1'b0;
                m_pend = cpu_req;
                m_rnw = cpu_rnw;
            end else if (scan_restart) begin
                m_restart = 1'b1;
            end
            if (ce && m_phase == 3) m_pend = 1'b0;
            if (ce) m_phase = (m_phase + 1) % 4;
        end
    endtask

    // One clock: inputs are stable across the posedge, outputs sampled on the negedge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ce = 1'b1; cpu_req = 1'b0; cpu_rnw = 1'b1; scan_restart = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ce = 1'b1; cpu_req = 1'b0; scan_restart = 1'b0;
        tick();
        tick();
        tests++;
        if ({nG, nSELA, nWE, vid_latch, cpu_ack} !== 5'b11100) begin
            failed++;
            $display("FAIL reset_outputs: got %b expected 11100",
                     {nG, nSELA, nWE, vid_latch, cpu_ack});
        end
        tests++;
        if (scan_addr !== 12'd0) begin
            failed++; $display("FAIL reset_scan: got %0d expected 0", scan_addr);
        end
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            tests++;
            if (nG !== 1'b0) begin
                failed++; $display("FAIL release_nG k=%0d: got %b expected 0", k, nG);
            end
            tests++;
            if (nSELA !== ((k % 4) < 2)) begin
                failed++; $display("FAIL release_nSELA k=%0d: got %b", k, nSELA);
            end
            tests++;
            if (vid_latch !== ((k % 4) == 1)) begin
                failed++; $display("FAIL release_vid_latch k=%0d: got %b", k, vid_latch);
            end
            tests++;
            if (scan_addr !== 12'((k + 2) / 4)) begin
                failed++;
                $display("FAIL release_scan k=%0d: got %0d expected %0d", k, scan_addr, (k + 2) / 4);
            end
        end
    endtask

    task automatic test_cpu_write();
        do_reset();
        cpu_req = 1'b1; cpu_rnw = 1'b0;
        tick();  // VID_LATCH
        tick();  // CPU_SETUP, request captured
        tests++;
        if ({nSELA, nWE, cpu_wait} !== 3'b011) begin
            failed++; $display("FAIL wr_setup: got %b expected 011", {nSELA, nWE, cpu_wait});
        end
        tick();  // CPU_ACCESS
        tests++;
        if ({nSELA, nWE, cpu_ack, cpu_wait} !== 4'b0001) begin
            failed++;
            $display("FAIL wr_access: got %b expected 0001", {nSELA, nWE, cpu_ack, cpu_wait});
        end
        tick();  // VID_SETUP, ack
        tests++;
        if ({nSELA, nWE, cpu_ack, cpu_wait} !== 4'b1110) begin
            failed++;
            $display("FAIL wr_ack: got %b expected 1110", {nSELA, nWE, cpu_ack, cpu_wait});
        end
        cpu_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if ({nWE, cpu_ack} !== 2'b10) begin
                failed++; $display("FAIL wr_after i=%0d: got %b expected 10", i, {nWE, cpu_ack});
            end
        end
    endtask

    task automatic test_cpu_read_late();
        do_reset();
        tick();  // VID_LATCH
        tick();  // capture edge passes with no request
        cpu_req = 1'b1; cpu_rnw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if ({nWE, cpu_ack, cpu_wait} !== {1'b1, i == 5, i != 5}) begin
                failed++;
                $display("FAIL rd_late i=%0d: got nWE/ack/wait %b expected %b", i,
                         {nWE, cpu_ack, cpu_wait}, {1'b1, i == 5, i != 5});
            end
        end
        cpu_req = 1'b0;
        tick();
        tests++;
        if (cpu_ack !== 1'b0) begin
            failed++; $display("FAIL rd_ack_width: got %b expected 0", cpu_ack);
        end
    endtask

    task automatic test_wrap_restart();
        do_reset();
        repeat (1999) tick();  // CPU_ACCESS with scan at 500
        tests++;
        if (scan_addr !== 12'd500 || nSELA !== 1'b0) begin
            failed++; $display("FAIL restart_pre: got %0d expected 500", scan_addr);
        end
        scan_restart = 1'b1;
        tick();
        scan_restart = 1'b0;
        tick();
        tests++;
        if (scan_addr !== 12'd500) begin
            failed++; $display("FAIL restart_hold: got %0d expected 500", scan_addr);
        end
        tick();
        tests++;
        if (scan_addr !== 12'd0) begin
            failed++; $display("FAIL restart_apply: got %0d expected 0", scan_addr);
        end
        repeat (4) tick();
        tests++;
        if (scan_addr !== 12'd1) begin
            failed++; $display("FAIL restart_clear: got %0d expected 1", scan_addr);
        end

        do_reset();
        repeat (8189) tick();
        tests++;
        if (scan_addr !== 12'd2047) begin
            failed++; $display("FAIL wrap_pre: got %0d expected 2047", scan_addr);
        end
        tick();
        tests++;
        if (scan_addr !== 12'd0) begin
            failed++; $display("FAIL wrap: got %0d expected 0", scan_addr);
        end

        do_reset();
        repeat (8189) tick();
        scan_restart = 1'b1;
        tick();
        scan_restart = 1'b0;
        tests++;
        if (scan_addr !== 12'd0) begin
            failed++; $display("FAIL wrap_restart: got %0d expected 0", scan_addr);
        end
        repeat (4) tick();
        tests++;
        if (scan_addr !== 12'd1) begin
            failed++; $display("FAIL wrap_restart_next: got %0d expected 1", scan_addr);
        end
    endtask

    task automatic test_ce_gating();
        int n;
        do_reset();
        cpu_req = 1'b1; cpu_rnw = 1'b1;
        for (int i = 0; i < 48; i++) begin
            ce = (i % 3 == 0);
            tick();
            n = i / 3 + 1;
            tests++;
            if ({nSELA, vid_latch, nWE, cpu_ack, cpu_wait} !==
                {(n % 4) < 2, (n % 4) == 1, 1'b1, i == 9, i < 9}) begin
                failed++;
                $display("FAIL ce_ctrl i=%0d: got %b expected %b", i,
                         {nSELA, vid_latch, nWE, cpu_ack, cpu_wait},
                         {(n % 4) < 2, (n % 4) == 1, 1'b1, i == 9, i < 9});
            end
            tests++;
            if (scan_addr !== 12'((n + 2) / 4)) begin
                failed++;
                $display("FAIL ce_scan i=%0d: got %0d expected %0d", i, scan_addr, (n + 2) / 4);
            end
            if (i == 9) cpu_req = 1'b0;
        end
        ce = 1'b1;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        cpu_req = 1'b1; cpu_rnw = 1'b0;
        repeat (3) tick();
        tests++;
        if (nWE !== 1'b0) begin
            failed++; $display("FAIL midrst_pre: nWE got %b expected 0", nWE);
        end
        rst = 1'b1;
        tick();
        tests++;
        if ({nWE, nG, cpu_ack, scan_addr} !== {3'b110, 12'd0}) begin
            failed++;
            $display("FAIL midrst: got nWE/nG/ack %b scan %0d expected 110 scan 0",
                     {nWE, nG, cpu_ack}, scan_addr);
        end
        rst = 1'b0; cpu_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (cpu_ack !== 1'b0) begin
                failed++; $display("FAIL midrst_noack i=%0d: got %b expected 0", i, cpu_ack);
            end
        end
    endtask

    task automatic test_random();
        logic [17:0] got;
        logic [17:0] exp;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            ce = ($urandom_range(0, 3) != 0);
            scan_restart = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) == 0);
            if (cpu_req && m_ack) begin
                cpu_req = 1'b0;
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req = 1'b1;
                cpu_rnw = 1'($urandom_range(0, 1));
            end
            tick();
            got = {nSELA, nG, vid_latch, nWE, cpu_ack, cpu_wait, scan_addr};
            exp = {m_phase < 2, m_ng, m_phase == 1, !(m_phase == 3 && m_pend && !m_rnw),
                   m_ack, cpu_req && !m_ack, 12'(m_scan)};
            tests++;
            if (got !== exp) begin
                failed++;
                $display("FAIL random i=%0d: got %b expected %b", i, got, exp);
            end
        end
        rst = 1'b0; scan_restart = 1'b0; cpu_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_cpu_write();
        test_cpu_read_late();
        test_wrap_restart();
        test_ce_gating();
        test_reset_mid_access();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
